// File: rtl/riscv_pkg.sv
// RV32I encoding constants: opcodes, func3/func7 fields and the canonical NOP.
`default_nettype none

package riscv_pkg;

    typedef logic [31:0] instruction_t;

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_ALU_NORMAL   = 7'b0000000;
    localparam logic [6:0] F7_ALU_MODIFIED = 7'b0100000;

    localparam instruction_t INSTR_NOP = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core: bus word, ALU operation, encode request, encoder FSM states.
`default_nettype none

package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        ALU_R = 2'd0,
        ALU_I = 2'd1,
        LUI   = 2'd2,
        AUIPC = 2'd3
    } enc_kind_t;

    typedef struct packed {
        enc_kind_t   kind;
        alu_op_t     alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_encode_comb.sv
// Combinational RV32I field packing and legality check for one encode request.
`default_nettype none

module instr_encode_comb
    import riscv_pkg::*;
    import tartaruga_pkg::*;
(
    input  logic [$bits(enc_req_t)-1:0] req,
    output instruction_t                word,
    output logic                        illegal
);

    enc_req_t   r;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       op_ok;
    logic       is_shift;

    assign r = enc_req_t'(req);

    always_comb begin
        func3    = F3_ADD_SUB;
        func7    = F7_ALU_NORMAL;
        op_ok    = 1'b1;
        is_shift = 1'b0;
        case (r.alu_op)
            ALU_ADD:  func3 = F3_ADD_SUB;
            ALU_SUB:  begin func3 = F3_ADD_SUB; func7 = F7_ALU_MODIFIED; end
            ALU_SLL:  begin func3 = F3_SLL; is_shift = 1'b1; end
            ALU_SLT:  func3 = F3_SLT;
            ALU_SLTU: func3 = F3_SLTU;
            ALU_XOR:  func3 = F3_XOR;
            ALU_SRL:  begin func3 = F3_SRL_SRA; is_shift = 1'b1; end
            ALU_SRA:  begin func3 = F3_SRL_SRA; func7 = F7_ALU_MODIFIED; is_shift = 1'b1; end
            ALU_OR:   func3 = F3_OR;
            ALU_AND:  func3 = F3_AND;
            default:  op_ok = 1'b0;
        endcase
    end

    always_comb begin
        word    = INSTR_NOP;
        illegal = 1'b0;
        case (r.kind)
            ALU_R: begin
                if (op_ok) word = {func7, r.rs2, r.rs1, func3, r.rd, OP_ALU};
                else       illegal = 1'b1;
            end
            ALU_I: begin
                // No SUBI exists; shift amounts are unsigned 0..31, others a sign-extended 12-bit immediate
                if (!op_ok || r.alu_op == ALU_SUB) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    if (|r.imm[31:5]) illegal = 1'b1;
                    else word = {func7, r.imm[4:0], r.rs1, func3, r.rd, OP_ALU_I};
                end else begin
                    if (r.imm[31:11] != {21{r.imm[11]}}) illegal = 1'b1;
                    else word = {r.imm[11:0], r.rs1, func3, r.rd, OP_ALU_I};
                end
            end
            LUI:     word = {r.imm[31:12], r.rd, OP_LUI};
            AUIPC:   word = {r.imm[31:12], r.rd, OP_AUIPC};
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// Program loader: encodes a stream of requests into RV32I words and writes them to sequential memory addresses.
`default_nettype none

module instr_encoder
    import riscv_pkg::*;
    import tartaruga_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  bus32_t       base_addr_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  enc_req_t     req_i,
    input  logic         last_i,
    output logic         mem_we_o,
    output bus32_t       mem_addr_o,
    output instruction_t mem_wdata_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic [15:0]  count_o
);

    enc_state_t   state;
    enc_state_t   state_nx;
    bus32_t       addr_ptr;
    instruction_t enc_word;
    logic         enc_illegal;
    logic         accept;

    instr_encode_comb u_comb (
        .req     (req_i),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign req_ready_o = (state == ST_RUN);
    assign busy_o      = (state != ST_IDLE);
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_i) state_nx = ST_RUN;
            ST_RUN:  if (accept && last_i) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Write port is registered: every accepted request lands in memory on the following cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            count_o     <= '0;
            addr_ptr    <= '0;
        end else begin
            mem_we_o <= 1'b0;
            done_o   <= 1'b0;
            if (state == ST_IDLE && start_i) begin
                addr_ptr <= base_addr_i;
                count_o  <= '0;
                error_o  <= 1'b0;
            end
            if (accept) begin
                mem_we_o    <= 1'b1;
                mem_wdata_o <= enc_word;
                mem_addr_o  <= addr_ptr;
                addr_ptr    <= addr_ptr + 32'd4;
                done_o      <= last_i;
                if (count_o != 16'hFFFF) count_o <= count_o + 16'd1;
                if (enc_illegal) error_o <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start_i, input, 1 bit: begin a program-load session at base_addr_i; sampled only in IDLE.
REQ-004 SHALL have port base_addr_i, input, bus32_t: first instruction-memory byte address.
REQ-005 SHALL have port req_valid_i, input, 1 bit: req_i holds a valid encode request.
REQ-006 SHALL have port req_ready_o, output, 1 bit: encoder accepts req_i this cycle.
REQ-007 SHALL have port req_i, input, enc_req_t: request fields kind, alu_op, rd, rs1, rs2, imm(32).
REQ-008 SHALL have port last_i, input, 1 bit: qualifies req_i as the final word of the session.
REQ-009 SHALL have port mem_we_o, output, 1 bit: instruction-memory write strobe.
REQ-010 SHALL have port mem_addr_o, output, bus32_t: write byte address.
REQ-011 SHALL have port mem_wdata_o, output, instruction_t: encoded RV32I word.
REQ-012 SHALL have port busy_o, output, 1 bit: session in progress.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse when the session's final word is written.
REQ-014 SHALL have port error_o, output, 1 bit: sticky illegal-request flag, cleared by start_i.
REQ-015 SHALL have port count_o, output, 16 bits: words written this session.

Function
REQ-016 SHALL implement FSM IDLE -> RUN on start_i; RUN -> DONE on acceptance with last_i=1; DONE -> IDLE unconditionally after one cycle.
REQ-017 SHALL drive req_ready_o=1 only in RUN; handshake is req_valid_i && req_ready_o.
REQ-018 SHALL write each accepted request exactly one cycle later: registered mem_we_o=1, mem_wdata_o, mem_addr_o.
REQ-019 SHALL start mem_addr_o at base_addr_i and add 4 per written word, wrapping modulo 2^32.
REQ-020 SHALL encode kind ALU_R as func7|rs2|rs1|func3|rd|OP_ALU; func7=F7_ALU_MODIFIED for SUB/SRA, else F7_ALU_NORMAL.
REQ-021 SHALL encode kind ALU_I as imm[11:0]|rs1|func3|rd|OP_ALU_I; SLL/SRL/SRA use func7|imm[4:0] in bits 31:20.
REQ-022 SHALL encode kinds LUI and AUIPC as imm[31:12]|rd|opcode; imm[11:0] ignored.
REQ-023 SHALL treat as illegal: ALU_I with SUB; ALU_I non-shift imm not sign-extended from bit 11; ALU_I shift imm > 31; undefined kind or alu_op.
REQ-024 SHALL write NOP 0x00000013 for an illegal request, still advance address and count, and set error_o.
REQ-025 SHALL assert done_o in the cycle mem_we_o writes the last word; busy_o=1 in RUN and DONE.
REQ-026 SHALL ignore start_i outside IDLE and req_valid_i outside RUN.
REQ-027 SHALL saturate count_o at 0xFFFF.

Reset
REQ-028 SHALL on rst_i force IDLE, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, req_ready_o=0, busy_o=0, done_o=0, error_o=0, count_o=0.
REQ-029 SHALL abandon a mid-session write on rst_i; no write strobe occurs in the cycle after reset release.

Structure
REQ-030 SHALL place enc_kind_t (ALU_R, ALU_I, LUI, AUIPC) and enc_req_t in tartaruga_pkg, reusing the existing alu_op type.
REQ-031 SHALL take opcodes, func3 and func7 constants from riscv_pkg.
REQ-032 SHALL isolate field packing and legality checks in combinational sub-module instr_encode_comb, with outputs word and illegal.

Verification
REQ-033 SHALL cover: base 0x100, ALU_I ADD rd=1 rs1=0 imm=5, last -> write 0x00500093 @0x100, done_o pulse, count_o=1.
REQ-034 SHALL cover: ALU_R SUB rd=3 rs1=1 rs2=2, then ALU_I SRA rd=5 rs1=6 imm=3 -> 0x402081B3 @base, 0x40335293 @base+4.
REQ-035 SHALL cover: LUI rd=7 imm=0x12345ABC -> 0x123453B7.
REQ-036 SHALL cover: ALU_I SUB, then ALU_I ADD imm=0x800 -> two 0x00000013 writes, error_o=1 until next start_i.
REQ-037 SHALL cover: base 0xFFFFFFFC, two requests -> addresses 0xFFFFFFFC then 0x00000000.
REQ-038 SHALL cover: rst_i asserted after 2 accepted words in RUN -> all outputs at reset values immediately, FSM IDLE.
